// File: rtl/jesd204b_lmfc_if.sv
// Bundle between the SYSREF/SYNC~ resynchroniser side and the LMFC generator.
// master drives sysref/sync/config; slave (the generator) drives status.
interface jesd204b_lmfc_gen_if #(
  parameter int CNT_W = 8
);
  logic             sysref_i;
  logic [3:0]       sync_b_i;
  logic             cfg_oneshot;
  logic [CNT_W-1:0] cfg_lmfc_offset;
  logic             realign;
  logic [CNT_W-1:0] lmfc_cnt;
  logic             lmfc_pulse;
  logic             aligned;
  logic             sysref_err;
  logic [7:0]       sysref_err_cnt;
  logic             sync_b_all;
  logic             ilas_start;
  logic             link_up;

  modport master (
    output sysref_i, sync_b_i, cfg_oneshot,
    output cfg_lmfc_offset, realign,
    input  lmfc_cnt, lmfc_pulse, aligned,
    input  sysref_err, sysref_err_cnt,
    input  sync_b_all, ilas_start, link_up
  );

  modport slave (
    input  sysref_i, sync_b_i, cfg_oneshot,
    input  cfg_lmfc_offset, realign,
    output lmfc_cnt, lmfc_pulse, aligned,
    output sysref_err, sysref_err_cnt,
    output sync_b_all, ilas_start, link_up
  );
endinterface

// File: rtl/jesd204b_lmfc_gen_if.sv
// Alias file for the LMFC generator interface.
// The definition lives in jesd204b_lmfc_if.sv.

// File: rtl/jesd204b_lmfc_gen.sv
// JESD204B RX LMFC generator and SYNC~ link controller.
// Ports: clk, reset_b (async low), bus (slave: sysref/sync/cfg in, LMFC/link status out).
module jesd204b_lmfc_gen #(
  parameter int LMFC_PERIOD = 16,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset_b,
  jesd204b_lmfc_gen_if.slave   bus
);

  typedef enum logic {
    A_WAIT,
    A_LOCK
  } align_t;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DATA
  } sync_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LMFC_PERIOD - 1);

  align_t           a_q, a_d;
  sync_t            s_q, s_d;
  logic             sysref_q;
  logic             sr_edge;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] offset;
  logic             pulse_q, pulse_d;
  logic             err_q, err_d;
  logic [7:0]       ecnt_q, ecnt_d;
  logic             sync_all_q;
  logic             aligned;
  logic             ilas;

  assign sr_edge = bus.sysref_i & ~sysref_q;
  assign aligned = (a_q == A_LOCK);

  // out-of-range offsets collapse to phase 0
  assign offset = (bus.cfg_lmfc_offset > LAST) ?
                  '0 : bus.cfg_lmfc_offset;

  assign cnt_inc = (cnt_q == LAST) ?
                   '0 : cnt_q + CNT_W'(1);

  always_comb begin
    a_d    = a_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    ecnt_d = ecnt_q;
    if (bus.realign) begin
      // realign beats a coincident edge
      a_d    = A_WAIT;
      cnt_d  = '0;
      err_d  = 1'b0;
      ecnt_d = '0;
    end else begin
      unique case (a_q)
        A_WAIT: begin
          if (sr_edge) begin
            a_d   = A_LOCK;
            cnt_d = offset;
          end
        end
        A_LOCK: begin
          cnt_d = cnt_inc;
          // edge must land where the counter
          // would have reached the offset anyway
          if (sr_edge && !bus.cfg_oneshot &&
              cnt_inc != offset) begin
            cnt_d = offset;
            err_d = 1'b1;
            if (ecnt_q != 8'hFF)
              ecnt_d = ecnt_q + 8'd1;
          end
        end
      endcase
    end
    pulse_d = (a_d == A_LOCK) && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      a_q        <= A_WAIT;
      sysref_q   <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
      err_q      <= 1'b0;
      ecnt_q     <= '0;
      sync_all_q <= 1'b0;
      s_q        <= S_REQ;
    end else begin
      a_q        <= a_d;
      sysref_q   <= bus.sysref_i;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      err_q      <= err_d;
      ecnt_q     <= ecnt_d;
      sync_all_q <= &bus.sync_b_i;
      s_q        <= s_d;
    end
  end

  always_comb begin
    s_d  = s_q;
    ilas = 1'b0;
    unique case (s_q)
      S_REQ: begin
        if (sync_all_q && aligned)
          s_d = S_WAIT;
      end
      S_WAIT: begin
        if (!aligned || !sync_all_q) begin
          s_d = S_REQ;
        end else if (pulse_q) begin
          ilas = 1'b1;
          s_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (!aligned || !sync_all_q)
          s_d = S_REQ;
      end
      default: s_d = S_REQ;
    endcase
  end

  assign bus.lmfc_cnt       = cnt_q;
  assign bus.lmfc_pulse     = pulse_q;
  assign bus.aligned        = aligned;
  assign bus.sysref_err     = err_q;
  assign bus.sysref_err_cnt = ecnt_q;
  assign bus.sync_b_all     = sync_all_q;
  assign bus.ilas_start     = ilas;
  assign bus.link_up        = (s_q == S_DATA);

endmodule

// File: tb/tb_jesd204b_lmfc_gen.sv
// Directed bench for jesd204b_lmfc_gen: vector table plus
// hand-written sequences for drift, saturation, SYNC~ and reset.
module tb_jesd204b_lmfc_gen;

  logic clk;
  logic reset_b;
  int   checks;
  int   errors;

  jesd204b_lmfc_gen_if #(.CNT_W(8)) bus ();

  jesd204b_lmfc_gen #(
    .LMFC_PERIOD(16),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_b(reset_b),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] outs;
  assign outs = {bus.lmfc_cnt, bus.lmfc_pulse,
                 bus.aligned, bus.sysref_err,
                 bus.sysref_err_cnt, bus.sync_b_all,
                 bus.link_up, bus.ilas_start};

  typedef struct {
    logic       sysref;
    logic       oneshot;
    logic [7:0] offset;
    logic       realign;
    logic [7:0] e_cnt;
    logic       e_pulse;
    logic       e_al;
    logic       e_err;
    logic [7:0] e_ecnt;
  } vec_t;

  vec_t vt[18];

  function automatic vec_t mk(
    input logic s, input logic o,
    input logic [7:0] off, input logic r,
    input logic [7:0] c, input logic p,
    input logic a, input logic e,
    input logic [7:0] ec);
    vec_t v;
    v.sysref = s; v.oneshot = o;
    v.offset = off; v.realign = r;
    v.e_cnt = c; v.e_pulse = p;
    v.e_al = a; v.e_err = e; v.e_ecnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.sysref_i        = 1'b0;
    bus.realign         = 1'b0;
    reset_b             = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
  endtask

  int  found;
  int  bad;

  initial begin
    checks = 0;
    errors = 0;
    reset_b = 1'b0;
    bus.sysref_i        = 1'b0;
    bus.sync_b_i        = 4'b0000;
    bus.cfg_oneshot     = 1'b0;
    bus.cfg_lmfc_offset = 8'd0;
    bus.realign         = 1'b0;
    #1;
    chk("reset_outs", 32'(outs), 32'd0);
    do_reset();
    chk("post_reset_outs", 32'(outs), 32'd0);

    //           s  o  off   r  cnt   p  a  e  ecnt
    vt[0]  = mk(0, 0, 8'd0,  0, 8'd0,  0, 0, 0, 8'd0);
    vt[1]  = mk(1, 0, 8'd3,  0, 8'd3,  0, 1, 0, 8'd0);
    vt[2]  = mk(1, 0, 8'd3,  0, 8'd4,  0, 1, 0, 8'd0);
    vt[3]  = mk(0, 0, 8'd3,  0, 8'd5,  0, 1, 0, 8'd0);
    vt[4]  = mk(1, 0, 8'd6,  0, 8'd6,  0, 1, 0, 8'd0);
    vt[5]  = mk(0, 0, 8'd6,  0, 8'd7,  0, 1, 0, 8'd0);
    vt[6]  = mk(1, 0, 8'd3,  0, 8'd3,  0, 1, 1, 8'd1);
    vt[7]  = mk(0, 0, 8'd3,  0, 8'd4,  0, 1, 1, 8'd1);
    vt[8]  = mk(1, 0, 8'd20, 0, 8'd0,  1, 1, 1, 8'd2);
    vt[9]  = mk(0, 0, 8'd20, 0, 8'd1,  0, 1, 1, 8'd2);
    vt[10] = mk(0, 0, 8'd0,  1, 8'd0,  0, 0, 0, 8'd0);
    vt[11] = mk(1, 0, 8'd0,  1, 8'd0,  0, 0, 0, 8'd0);
    vt[12] = mk(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 8'd0);
    vt[13] = mk(0, 0, 8'd0,  0, 8'd0,  0, 0, 0, 8'd0);
    vt[14] = mk(1, 0, 8'd15, 0, 8'd15, 0, 1, 0, 8'd0);
    vt[15] = mk(0, 0, 8'd15, 0, 8'd0,  1, 1, 0, 8'd0);
    vt[16] = mk(1, 1, 8'd7,  0, 8'd1,  0, 1, 0, 8'd0);
    vt[17] = mk(0, 1, 8'd7,  0, 8'd2,  0, 1, 0, 8'd0);

    for (int i = 0; i < 18; i++) begin
      bus.sysref_i        = vt[i].sysref;
      bus.cfg_oneshot     = vt[i].oneshot;
      bus.cfg_lmfc_offset = vt[i].offset;
      bus.realign         = vt[i].realign;
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(outs),
          32'({vt[i].e_cnt, vt[i].e_pulse,
               vt[i].e_al, vt[i].e_err,
               vt[i].e_ecnt, 3'b000}));
    end

    // continuous mode, edges every 64 cycles
    bus.cfg_oneshot     = 1'b0;
    bus.cfg_lmfc_offset = 8'd0;
    bus.realign         = 1'b0;
    do_reset();
    bad = 0;
    for (int e = 0; e < 10; e++) begin
      bus.sysref_i = 1'b1;
      @(negedge clk);
      bus.sysref_i = 1'b0;
      if ({bus.lmfc_cnt, bus.lmfc_pulse,
           bus.aligned} !== {8'd0, 2'b11})
        bad++;
      for (int k = 1; k < 64; k++) begin
        @(negedge clk);
        if (bus.lmfc_cnt !== 8'(k % 16) ||
            bus.lmfc_pulse !== (k % 16 == 0))
          bad++;
      end
    end
    chk("periodic_phase", 32'(bad), 32'd0);
    chk("periodic_err",
        32'({bus.sysref_err, bus.sysref_err_cnt}),
        32'd0);

    // one edge shifted +3 cycles
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("pre_shift_cnt", 32'(bus.lmfc_cnt), 32'd2);
    bus.sysref_i = 1'b1;
    @(negedge clk);
    chk("shift_realigned",
        32'({bus.lmfc_cnt, bus.sysref_err,
             bus.sysref_err_cnt}),
        32'({8'd0, 1'b1, 8'd1}));

    // every edge off-phase until saturation
    for (int i = 0; i < 300; i++) begin
      bus.sysref_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      bus.sysref_i = 1'b1;
      @(negedge clk);
      if (i == 252)
        chk("ecnt_254", 32'(bus.sysref_err_cnt),
            32'd254);
    end
    bus.sysref_i = 1'b0;
    chk("ecnt_sat", 32'(bus.sysref_err_cnt),
        32'd255);

    // realign clears, then one-shot offset 5
    bus.realign = 1'b1;
    @(negedge clk);
    bus.realign = 1'b0;
    chk("realign_clear", 32'(outs), 32'd0);
    bus.cfg_oneshot     = 1'b1;
    bus.cfg_lmfc_offset = 8'd5;
    bus.sysref_i        = 1'b1;
    @(negedge clk);
    bus.sysref_i = 1'b0;
    chk("oneshot_load",
        32'({bus.lmfc_cnt, bus.aligned}),
        32'({8'd5, 1'b1}));
    repeat (4) @(negedge clk);
    bus.sysref_i = 1'b1;
    @(negedge clk);
    bus.sysref_i = 1'b0;
    chk("oneshot_ignore",
        32'({bus.lmfc_cnt, bus.sysref_err,
             bus.sysref_err_cnt}),
        32'({8'd10, 1'b0, 8'd0}));

    // SYNC~ release and ILAS at LMFC boundary
    bus.sync_b_i = 4'b1111;
    @(negedge clk);
    chk("sync_all_up", 32'(bus.sync_b_all), 32'd1);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (bus.ilas_start) begin
        found = 1;
        chk("ilas_at_pulse",
            32'({bus.lmfc_pulse, bus.lmfc_cnt,
                 bus.link_up}),
            32'({1'b1, 8'd0, 1'b0}));
      end
    end
    chk("ilas_seen", 32'(found), 32'd1);
    @(negedge clk);
    chk("link_up",
        32'({bus.link_up, bus.ilas_start}),
        32'b10);
    bus.sync_b_i = 4'b1011;
    @(negedge clk);
    chk("lane_req_1",
        32'({bus.sync_b_all, bus.link_up}),
        32'b01);
    @(negedge clk);
    chk("lane_req_2", 32'(bus.link_up), 32'd0);

    // bring link back up, then realign + coincident edge
    bus.sync_b_i = 4'b1111;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (bus.link_up) found = 1;
    end
    chk("link_reup", 32'(found), 32'd1);
    bus.cfg_oneshot     = 1'b0;
    bus.cfg_lmfc_offset = 8'd20;
    bus.sysref_i        = 1'b1;
    bus.realign         = 1'b1;
    @(negedge clk);
    bus.realign = 1'b0;
    chk("realign_edge",
        32'({bus.lmfc_cnt, bus.aligned,
             bus.sysref_err, bus.sysref_err_cnt}),
        32'd0);
    @(negedge clk);
    chk("realign_drop",
        32'({bus.aligned, bus.link_up,
             bus.ilas_start}),
        32'd0);
    @(negedge clk);
    chk("no_edge_held", 32'(bus.aligned), 32'd0);
    bus.sysref_i = 1'b0;
    @(negedge clk);
    bus.sysref_i = 1'b1;
    @(negedge clk);
    bus.sysref_i = 1'b0;
    chk("off20_loads0",
        32'({bus.lmfc_cnt, bus.lmfc_pulse,
             bus.aligned}),
        32'({8'd0, 2'b11}));

    // async reset while in DATA
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (bus.link_up) found = 1;
    end
    chk("data_before_rst", 32'(found), 32'd1);
    @(negedge clk);
    #2 reset_b = 1'b0;
    #1;
    chk("async_reset", 32'(outs), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.lmfc_pulse !== 1'b0 ||
          bus.aligned !== 1'b0 ||
          bus.ilas_start !== 1'b0)
        bad++;
    end
    chk("no_pulse_after_rst", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
